// File: rtl/joystick_hub_pkg.sv
// Shared constants for the joystick hub: parameter defaults, FSM state codes
// and the channel-index width helper.
package joystick_hub_pkg;

  localparam int NUM_CH_DEF = 8;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 8;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  // A single channel still needs a 1-bit index.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/joystick_hub_if.sv
// Presentation handshake between the hub and its consumer.
interface joystick_hub_if
  import joystick_hub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CH_W   = 3
);
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              out_ack;

  modport master (output out_valid, output out_ch, output out_data, input out_ack);
  modport slave  (input out_valid, input out_ch, input out_data, output out_ack);
endinterface

// File: rtl/joystick_hub_rr_arbiter.sv
// Combinational round-robin pick: first requester above the last grant, with wrap.
module rr_arbiter
  import joystick_hub_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = ch_w(NUM_CH_DEF)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_vld
);
  logic [CH_W-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    // k = NUM_CH revisits the last winner so a lone requester is still served.
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last) + k) % NUM_CH);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
endmodule

// File: rtl/joystick_hub.sv
// Joystick hub: latches per-channel words, arbitrates pending channels
// round-robin and presents one word at a time over a valid/ack handshake.
module joystick_hub
  import joystick_hub_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        irq_mask,
  joystick_hub_if.master           out_bus,
  output logic                     irq,
  output logic [NUM_CH-1:0]        pending,
  output logic [CNT_W-1:0]         overrun_cnt,
  input  logic                     clear_overrun
);
  localparam int CH_W = ch_w(NUM_CH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] data_p0 [NUM_CH];
  logic [NUM_CH-1:0] pend_p0, pend_nxt, req, gnt_hot, ovr_hot;
  logic [0:0]        state_p0;
  logic [CH_W-1:0]   last_p0, gnt_idx, out_ch_p1;
  logic [DATA_W-1:0] out_data_p1;
  logic [CNT_W-1:0]  cnt_p0;
  logic              gnt_vld, grant_fire, irq_p0;

  assign req = pend_p0 & irq_mask;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req     (req),
    .last    (last_p0),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign grant_fire = (state_p0 == ST_IDLE) && gnt_vld;

  always_comb begin
    gnt_hot = '0;
    for (int i = 0; i < NUM_CH; i++) gnt_hot[i] = grant_fire && (gnt_idx == CH_W'(i));
  end

  // A write landing on the channel being granted re-arms it instead of overrunning.
  assign ovr_hot  = ch_valid & pend_p0 & ~gnt_hot;
  assign pend_nxt = ch_valid | (pend_p0 & ~gnt_hot);

  // Stage p0: per-channel capture
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset)            data_p0[i] <= '0;
      else if (ch_valid[i]) data_p0[i] <= ch_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_p0 <= '0;
      irq_p0  <= 1'b0;
      cnt_p0  <= '0;
    end else begin
      pend_p0 <= pend_nxt;
      irq_p0  <= |(pend_nxt & irq_mask);
      if (clear_overrun)  cnt_p0 <= '0;
      else if (|ovr_hot)  cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  // Stage p1: presentation register and FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0    <= ST_IDLE;
      last_p0     <= CH_W'(NUM_CH - 1);
      out_ch_p1   <= '0;
      out_data_p1 <= '0;
    end else if (state_p0 == ST_IDLE) begin
      if (grant_fire) begin
        state_p0    <= ST_PRESENT;
        last_p0     <= gnt_idx;
        out_ch_p1   <= gnt_idx;
        out_data_p1 <= data_p0[gnt_idx];
      end
    end else if (out_bus.out_ack) begin
      state_p0 <= ST_IDLE;
    end
  end

  assign out_bus.out_valid = (state_p0 == ST_PRESENT);
  assign out_bus.out_ch    = out_ch_p1;
  assign out_bus.out_data  = out_data_p1;
  assign irq               = irq_p0;
  assign pending           = pend_p0;
  assign overrun_cnt       = cnt_p0;
endmodule

// File: tb/tb_joystick_hub.sv
// Directed bench for joystick_hub; a second instance with a 2-bit counter
// shares all inputs to exercise counter saturation.
module tb_joystick_hub;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 64;
  localparam int CH_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        irq_mask;
  logic                     clear_overrun;
  logic                     ack;
  logic                     irq, irq_s;
  logic [NUM_CH-1:0]        pending, pending_s;
  logic [7:0]               ovr;
  logic [1:0]               ovr_s;

  int n_tests = 0;
  int n_fail  = 0;

  joystick_hub_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();
  joystick_hub_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus_s ();

  assign bus.out_ack   = ack;
  assign bus_s.out_ack = ack;

  joystick_hub #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .irq_mask(irq_mask), .out_bus(bus), .irq(irq), .pending(pending),
    .overrun_cnt(ovr), .clear_overrun(clear_overrun)
  );

  joystick_hub #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .irq_mask(irq_mask), .out_bus(bus_s), .irq(irq_s), .pending(pending_s),
    .overrun_cnt(ovr_s), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int ch, input logic [63:0] w);
    ch_data[ch*DATA_W +: DATA_W] = w;
  endtask

  initial begin
    reset = 1'b1; ch_valid = '0; ch_data = '0; irq_mask = '0;
    clear_overrun = 1'b0; ack = 1'b0;
    tick(); tick();
    chk("rst_valid",   64'(bus.out_valid), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_irq",     64'(irq), 64'd0);
    chk("rst_ovr",     64'(ovr), 64'd0);
    chk("rst_ch",      64'(bus.out_ch), 64'd0);
    chk("rst_data",    bus.out_data, 64'd0);
    chk("rst_pend_s",  64'(pending_s), 64'd0);
    chk("rst_irq_s",   64'(irq_s), 64'd0);
    reset = 1'b0; irq_mask = 8'hFF;

    // single request on channel 3
    set_word(3, 64'h0000_00AA_0000_0055); ch_valid = 8'h08;
    tick();
    chk("t1_irq",   64'(irq), 64'd1);
    chk("t1_pend",  64'(pending), 64'h08);
    chk("t1_noval", 64'(bus.out_valid), 64'd0);
    ch_valid = '0;
    tick();
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_ch",    64'(bus.out_ch), 64'd3);
    chk("t1_data",  bus.out_data, 64'h0000_00AA_0000_0055);
    chk("t1_pend0", 64'(pending), 64'd0);
    chk("t1_irq0",  64'(irq), 64'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t1_drop",  64'(bus.out_valid), 64'd0);

    reset = 1'b1; tick(); reset = 1'b0;

    // round robin over 1, 4, 6 then 1, 4
    set_word(1, 64'h1111); set_word(4, 64'h4444); set_word(6, 64'h6666);
    ch_valid = 8'h52;
    tick();
    chk("t2_pend", 64'(pending), 64'h52);
    ch_valid = '0; ack = 1'b1;
    tick();
    chk("t2_g1",   64'(bus.out_ch), 64'd1);
    chk("t2_v1",   64'(bus.out_valid), 64'd1);
    tick();
    chk("t2_bubble", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t2_g4",   64'(bus.out_ch), 64'd4);
    chk("t2_d4",   bus.out_data, 64'h4444);
    tick(); tick();
    chk("t2_g6",   64'(bus.out_ch), 64'd6);
    chk("t2_p6",   64'(pending), 64'd0);
    tick();
    ch_valid = 8'h12;
    tick();
    ch_valid = '0;
    tick();
    chk("t2_r1",   64'(bus.out_ch), 64'd1);
    tick(); tick();
    chk("t2_r4",   64'(bus.out_ch), 64'd4);
    tick(); ack = 1'b0;

    // overruns on channel 2 while channel 5 is presented
    set_word(5, 64'h5555); ch_valid = 8'h20;
    tick();
    ch_valid = '0;
    tick();
    chk("t3_g5",   64'(bus.out_ch), 64'd5);
    irq_mask = 8'hDF;
    set_word(2, 64'h2001); ch_valid = 8'h04; tick();
    set_word(2, 64'h2002); tick();
    set_word(2, 64'h2003); tick();
    ch_valid = '0;
    chk("t3_ovr",   64'(ovr), 64'd2);
    chk("t3_hold",  64'(bus.out_ch), 64'd5);
    chk("t3_hdata", bus.out_data, 64'h5555);
    chk("t3_keepv", 64'(bus.out_valid), 64'd1);
    chk("t3_pend",  64'(pending), 64'h04);
    irq_mask = 8'hFF;
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    chk("t3_g2",   64'(bus.out_ch), 64'd2);
    chk("t3_d2",   bus.out_data, 64'h2003);
    ack = 1'b1; tick(); ack = 1'b0;

    // write to channel 0 in the cycle it is granted
    set_word(0, 64'hA0A0); ch_valid = 8'h01;
    tick();
    set_word(0, 64'hB0B0);
    tick();
    ch_valid = '0;
    chk("t4_g0",   64'(bus.out_ch), 64'd0);
    chk("t4_old",  bus.out_data, 64'hA0A0);
    chk("t4_pend", 64'(pending), 64'h01);
    chk("t4_ovr",  64'(ovr), 64'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    chk("t4_new",  bus.out_data, 64'hB0B0);
    chk("t4_ch",   64'(bus.out_ch), 64'd0);
    chk("t4_pend0", 64'(pending), 64'd0);
    ack = 1'b1; tick(); ack = 1'b0;

    // counter saturation and clear priority on a masked channel
    clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
    chk("t5_clr",   64'(ovr), 64'd0);
    chk("t5_clr_s", 64'(ovr_s), 64'd0);
    irq_mask = 8'h7F; set_word(7, 64'h7777); ch_valid = 8'h80;
    for (int i = 0; i < 6; i++) tick();
    ch_valid = '0;
    chk("t5_ovr",   64'(ovr), 64'd5);
    chk("t5_sat",   64'(ovr_s), 64'd3);
    chk("t5_pend",  64'(pending), 64'h80);
    chk("t5_irq",   64'(irq), 64'd0);
    chk("t5_nogr",  64'(bus.out_valid), 64'd0);
    ch_valid = 8'h80; clear_overrun = 1'b1;
    tick();
    ch_valid = '0; clear_overrun = 1'b0;
    chk("t5_pri",   64'(ovr), 64'd0);
    chk("t5_pri_s", 64'(ovr_s), 64'd0);

    // reset while presenting with three channels pending
    irq_mask = 8'hFF; ch_valid = 8'h0E;
    tick();
    ch_valid = '0;
    chk("t6_g7",   64'(bus.out_ch), 64'd7);
    chk("t6_v",    64'(bus.out_valid), 64'd1);
    chk("t6_pend", 64'(pending), 64'h0E);
    chk("t6_irq",  64'(irq), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rv",   64'(bus.out_valid), 64'd0);
    chk("t6_rp",   64'(pending), 64'd0);
    chk("t6_ri",   64'(irq), 64'd0);
    chk("t6_rv_s", 64'(bus_s.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/joystick_hub.md
JOYSTICK_HUB -- requirements
Module: joystick_hub

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL take parameter NUM_CH, default 8, number of joystick channels (1..16).
REQ-003 SHALL take parameter DATA_W, default 64, channel word width (LSB/MSB 32-bit halves).
REQ-004 SHALL take parameter CNT_W, default 8, overrun counter width.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port ch_valid  in  NUM_CH  per-channel new-word strobe.
REQ-008 SHALL have port ch_data  in  NUM_CH*DATA_W  channel words; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port irq_mask  in  NUM_CH  1 = channel may be granted and may raise irq.
REQ-010 SHALL have port out_valid  out  1  presented word valid.
REQ-011 SHALL have port out_ch  out  CH_W  index of the presented channel, CH_W = max(1, clog2(NUM_CH)).
REQ-012 SHALL have port out_data  out  DATA_W  presented word.
REQ-013 SHALL have port out_ack  in  1  consumer accepts the presented word.
REQ-014 SHALL have port irq  out  1  OR of (pending & irq_mask), registered.
REQ-015 SHALL have port pending  out  NUM_CH  per-channel pending flags.
REQ-016 SHALL have port overrun_cnt  out  CNT_W  saturating count of overwritten unconsumed words.
REQ-017 SHALL have port clear_overrun  in  1  zeroes overrun_cnt.

Function
REQ-018 SHALL hold one DATA_W register and one pending bit per channel.
REQ-019 SHALL, on ch_valid[i], capture ch_data for channel i and set pending[i] on the next edge.
REQ-020 SHALL, on ch_valid[i] while pending[i]=1 and channel i is not granted that cycle, overwrite the held word (latest wins) and increment overrun_cnt once per cycle, saturating at 2^CNT_W-1.
REQ-021 SHALL increment overrun_cnt by 1 when several channels overrun in the same cycle.
REQ-022 SHALL give clear_overrun priority over a same-cycle increment, leaving overrun_cnt 0.
REQ-023 SHALL implement FSM IDLE/PRESENT: IDLE with any (pending & irq_mask) -> grant one channel, load out_data/out_ch, clear its pending bit, go to PRESENT; PRESENT with out_ack -> drop out_valid, go to IDLE.
REQ-024 SHALL select the grant round-robin, searching from last granted index + 1 upward with wrap; after reset, last granted index is NUM_CH-1, so channel 0 has priority first.
REQ-025 SHALL assert out_valid exactly while in PRESENT and keep out_data/out_ch stable until out_ack.
REQ-026 SHALL give latency from ch_valid (cycle t) to out_valid high of 2 cycles when IDLE with nothing pending; one IDLE bubble SHALL follow every ack.
REQ-027 SHALL, on ch_valid[i] in the same cycle channel i is granted, present the old word and leave pending[i]=1 holding the new word, with no overrun.
REQ-028 SHALL ignore out_ack while out_valid=0.
REQ-029 SHALL NOT retract a presented word when its irq_mask bit is cleared during PRESENT.
REQ-030 SHALL keep masked pending channels pending and not granted.
REQ-031 SHALL register irq from the next-state pending & irq_mask, so irq rises in the same cycle as pending.

Reset
REQ-032 SHALL, on reset, clear pending, data registers, out_data, out_ch, out_valid, irq and overrun_cnt to 0, set FSM to IDLE, and set last granted index to NUM_CH-1.
REQ-033 SHALL let reset asserted mid-PRESENT drop out_valid on the next edge and discard all pending words.

Structure
REQ-034 SHALL place the FSM state enum, parameter defaults and the CH_W clog2 helper in package joystick_hub_pkg.
REQ-035 SHALL put the round-robin selection in one sub-module, rr_arbiter (request vector, last index -> grant index, grant valid), which is combinational.

Verification
REQ-036 SHALL verify: reset, then ch_valid[3] with data 0x0000_00AA_0000_0055 and mask 0xFF -> out_valid at t+2, out_ch=3, irq=1 at t+1, pending[3]=0 after grant.
REQ-037 SHALL verify: channels 1, 4 and 6 pending with out_ack every PRESENT cycle -> grant order 1, 4, 6; a later re-request on 1 and 4 -> order 1, 4.
REQ-038 SHALL verify: ch_valid[2] pulsed 3 times with no ack while channel 5 is presented -> overrun_cnt=2 and channel 2 presents the third word.
REQ-039 SHALL verify: CNT_W=2 with 5 overruns -> overrun_cnt=3; clear_overrun together with an overrun -> 0.
REQ-040 SHALL verify: ch_valid[0] in the grant cycle of channel 0 -> old word presented, pending[0]=1, overrun_cnt unchanged, new word presented after ack.
REQ-041 SHALL verify: reset asserted in PRESENT with 3 channels pending -> next cycle out_valid=0, pending=0, irq=0.
